// File: rtl/pulse_resp_pkg.sv
// Shared types and defaults for the pulse responder: FSM state encoding and
// the width of the internal delay/width counter.
package pulse_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StPulse
  } state_e;

  localparam int unsigned DefDelay = 2;
  localparam int unsigned DefWidth = 3;
  localparam int unsigned CntW     = 4;

  typedef logic [CntW-1:0] cnt_t;

endpackage

// File: rtl/pulse_edge_det.sv
// Registered rising-edge detector. The history flop follows d even in reset,
// so a level held across reset release never looks like an edge.
module pulse_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk) begin
    in_q <= d;
  end

  assign rise = d & ~in_q & ~rst;

endmodule

// File: rtl/pulse_responder.sv
// Answers each accepted rising edge of in_signal with a WIDTH-cycle pulse
// DELAY cycles later; edges arriving while busy are dropped and flagged.
module pulse_responder
  import pulse_resp_pkg::*;
#(
  parameter int unsigned DELAY = DefDelay,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_signal,
  output logic             out_signal,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] evt_count
);

  state_e           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             out_q;
  logic             overrun_q;
  logic [CNT_W-1:0] evt_q;
  logic             rise;
  logic             accept;
  logic             drop;

  pulse_edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .d    (in_signal),
    .rise (rise)
  );

  // One counter serves both the WAIT and PULSE phases; they never overlap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          accept = 1'b1;
          if (DELAY > 1) begin
            state_d = StWait;
            cnt_d   = cnt_t'(DELAY - 2);
          end else begin
            state_d = StPulse;
            cnt_d   = cnt_t'(WIDTH - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = cnt_t'(WIDTH - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign drop = rise & (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      overrun_q <= 1'b0;
      evt_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= (state_q == StPulse);
      if (drop) begin
        overrun_q <= 1'b1;
      end
      if (accept && (evt_q != {CNT_W{1'b1}})) begin
        evt_q <= evt_q + 1'b1;
      end
    end
  end

  assign out_signal = out_q;
  assign overrun    = overrun_q;
  assign evt_count  = evt_q;
  // out_q trails the PULSE state by a cycle; keep busy up over that tail.
  assign busy       = (state_q != StIdle) | out_q;

  a_out_busy : assert property (@(posedge clk) disable iff (rst) out_signal |-> busy);

  a_overrun_sticky : assert property (@(posedge clk) $fell(overrun) |-> $past(rst));

  a_pulse_width : assert property (@(posedge clk) disable iff (rst)
    $rose(out_signal) |-> ##WIDTH $fell(out_signal));

endmodule
